// File: rtl/seq_control_fsm_if.sv
// Sequencer handshake bundle: core-side control inputs and the enable,
// status and count outputs of seq_control_fsm.
//   start, opcode, branch, ALU_zero, imem_ready, dmem_ready : to sequencer
//   imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we,
//   pc_we, pc_sel, state, instr_count, halted, err          : from sequencer
interface seq_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic [6:0]       opcode;
  logic             branch;
  logic             ALU_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_we;
  logic             alu_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             pc_we;
  logic             pc_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic             err;

  // Datapath / core side
  modport master (
    output start, opcode, branch, ALU_zero, imem_ready, dmem_ready,
    input  imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we,
           pc_we, pc_sel, state, instr_count, halted, err
  );

  // Sequencer side
  modport slave (
    input  start, opcode, branch, ALU_zero, imem_ready, dmem_ready,
    output imem_req, ir_we, alu_en, dmem_req, dmem_we, reg_we,
           pc_we, pc_sel, state, instr_count, halted, err
  );
endinterface

// File: rtl/seq_control_fsm.sv
// Multi-cycle sequencer for the sequential RISC-V core.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : seq_control_fsm_if.slave (control inputs, phase enables, status)
// Enables are decoded from the state register plus inputs; instr_count and
// err are the only other registered outputs.
module seq_control_fsm #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  seq_control_fsm_if.slave bus
);

  localparam int unsigned WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [6:0]  OP_LOAD   = 7'h03;
  localparam logic [6:0]  OP_STORE  = 7'h23;
  localparam logic [6:0]  OP_BRANCH = 7'h63;
  localparam logic [6:0]  OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PC_UPDATE = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_instr_count;
  logic               r_err;

  state_t             w_next_state;
  logic [WAIT_W-1:0]  w_wait_nxt;
  logic               w_timeout;
  logic               w_count_en;
  logic               w_imem_req;
  logic               w_ir_we;
  logic               w_alu_en;
  logic               w_dmem_req;
  logic               w_dmem_we;
  logic               w_reg_we;
  logic               w_pc_we;
  logic               w_pc_sel;
  logic               w_limit;

  // The wait cycle that would bring the counter to MEM_WAIT_MAX is the last allowed
  assign w_limit = (r_wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  // State, wait counter, retire counter and sticky fault
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_instr_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_nxt;
      if (w_timeout)  r_err         <= 1'b1;
      if (w_count_en) r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // Next state and phase enables
  always_comb begin
    w_next_state = r_state;
    w_wait_nxt   = '0;
    w_timeout    = 1'b0;
    w_count_en   = 1'b0;
    w_imem_req   = 1'b0;
    w_ir_we      = 1'b0;
    w_alu_en     = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_reg_we     = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_we      = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_limit) begin
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        w_next_state = (bus.opcode == OP_SYSTEM) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        w_alu_en = 1'b1;
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMORY;
          OP_BRANCH:         w_next_state = S_PC_UPDATE;
          default:           w_next_state = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (bus.opcode == OP_STORE);
        if (bus.dmem_ready) begin
          w_next_state = (bus.opcode == OP_STORE) ? S_PC_UPDATE : S_WRITEBACK;
        end else if (w_limit) begin
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        w_reg_we     = 1'b1;
        w_next_state = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        w_pc_we      = 1'b1;
        w_pc_sel     = bus.branch & bus.ALU_zero;
        w_count_en   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = w_imem_req;
  assign bus.ir_we       = w_ir_we;
  assign bus.alu_en      = w_alu_en;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.dmem_we     = w_dmem_we;
  assign bus.reg_we      = w_reg_we;
  assign bus.pc_we       = w_pc_we;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.state       = r_state;
  assign bus.instr_count = r_instr_count;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.err         = r_err;

endmodule

// File: tb/tb_seq_control_fsm.sv
// Directed bench for seq_control_fsm: per-cycle vector table for the main
// instruction flows, plus hand-written timeout, async-reset and wrap sequences.
module tb_seq_control_fsm;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  seq_control_fsm_if #(.CNT_W(4)) bus ();

  seq_control_fsm #(
    .CNT_W        (4),
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable mask bit order: imem_req ir_we alu_en dmem_req dmem_we reg_we pc_we pc_sel
  typedef struct {
    logic       start;
    logic [6:0] op;
    logic       br;
    logic       z;
    logic       ir;
    logic       dr;
    logic [2:0] st;
    logic [7:0] en;
    logic       halted;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic start, input logic [6:0] op,
                              input logic br, input logic z, input logic ir,
                              input logic dr, input logic [2:0] st,
                              input logic [7:0] en, input logic halted,
                              input logic [3:0] cnt);
    vec_t v;
    v.start = start; v.op = op; v.br = br; v.z = z; v.ir = ir; v.dr = dr;
    v.st = st; v.en = en; v.halted = halted; v.err = 1'b0; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [7:0] en_mask();
    return {bus.imem_req, bus.ir_we, bus.alu_en, bus.dmem_req,
            bus.dmem_we, bus.reg_we, bus.pc_we, bus.pc_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [6:0] op, input logic br,
                       input logic z, input logic ir, input logic dr);
    bus.start = start; bus.opcode = op; bus.branch = br;
    bus.ALU_zero = z; bus.imem_ready = ir; bus.dmem_ready = dr;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  32'(bus.state), 32'd0);
    check({tag, "_en"},     32'(en_mask()), 32'd0);
    check({tag, "_cnt"},    32'(bus.instr_count), 32'd0);
    check({tag, "_err"},    32'(bus.err), 32'd0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // ALU op
    tbl[0]  = mk(1, 7'h33, 0, 0, 0, 0, 3'd0, 8'h00, 0, 4'd0);
    tbl[1]  = mk(0, 7'h33, 0, 0, 1, 0, 3'd1, 8'hC0, 0, 4'd0);
    tbl[2]  = mk(0, 7'h33, 0, 0, 1, 0, 3'd2, 8'h00, 0, 4'd0);
    tbl[3]  = mk(0, 7'h33, 0, 0, 1, 0, 3'd3, 8'h20, 0, 4'd0);
    tbl[4]  = mk(0, 7'h33, 0, 0, 1, 0, 3'd5, 8'h04, 0, 4'd0);
    tbl[5]  = mk(0, 7'h33, 0, 0, 1, 0, 3'd6, 8'h02, 0, 4'd0);
    // Branch taken (start high is ignored outside IDLE)
    tbl[6]  = mk(1, 7'h63, 1, 1, 1, 0, 3'd1, 8'hC0, 0, 4'd1);
    tbl[7]  = mk(0, 7'h63, 1, 1, 1, 0, 3'd2, 8'h00, 0, 4'd1);
    tbl[8]  = mk(0, 7'h63, 1, 1, 1, 0, 3'd3, 8'h20, 0, 4'd1);
    tbl[9]  = mk(0, 7'h63, 1, 1, 1, 0, 3'd6, 8'h03, 0, 4'd1);
    // Branch not taken
    tbl[10] = mk(0, 7'h63, 1, 0, 1, 0, 3'd1, 8'hC0, 0, 4'd2);
    tbl[11] = mk(0, 7'h63, 1, 0, 1, 0, 3'd2, 8'h00, 0, 4'd2);
    tbl[12] = mk(0, 7'h63, 1, 0, 1, 0, 3'd3, 8'h20, 0, 4'd2);
    tbl[13] = mk(0, 7'h63, 1, 0, 1, 0, 3'd6, 8'h02, 0, 4'd2);
    // Load, dmem_ready low for 3 cycles
    tbl[14] = mk(0, 7'h03, 0, 1, 1, 0, 3'd1, 8'hC0, 0, 4'd3);
    tbl[15] = mk(0, 7'h03, 0, 1, 1, 0, 3'd2, 8'h00, 0, 4'd3);
    tbl[16] = mk(0, 7'h03, 0, 1, 1, 0, 3'd3, 8'h20, 0, 4'd3);
    tbl[17] = mk(0, 7'h03, 0, 1, 1, 0, 3'd4, 8'h10, 0, 4'd3);
    tbl[18] = mk(0, 7'h03, 0, 1, 1, 0, 3'd4, 8'h10, 0, 4'd3);
    tbl[19] = mk(0, 7'h03, 0, 1, 1, 0, 3'd4, 8'h10, 0, 4'd3);
    tbl[20] = mk(0, 7'h03, 0, 1, 1, 1, 3'd4, 8'h10, 0, 4'd3);
    tbl[21] = mk(0, 7'h03, 0, 1, 1, 1, 3'd5, 8'h04, 0, 4'd3);
    tbl[22] = mk(0, 7'h03, 0, 1, 1, 1, 3'd6, 8'h02, 0, 4'd3);
    // Store: no writeback phase
    tbl[23] = mk(0, 7'h23, 0, 0, 1, 1, 3'd1, 8'hC0, 0, 4'd4);
    tbl[24] = mk(0, 7'h23, 0, 0, 1, 1, 3'd2, 8'h00, 0, 4'd4);
    tbl[25] = mk(0, 7'h23, 0, 0, 1, 1, 3'd3, 8'h20, 0, 4'd4);
    tbl[26] = mk(0, 7'h23, 0, 0, 1, 1, 3'd4, 8'h18, 0, 4'd4);
    tbl[27] = mk(0, 7'h23, 0, 0, 1, 1, 3'd6, 8'h02, 0, 4'd4);
    // Fetch stall, then system instruction halts uncounted
    tbl[28] = mk(0, 7'h73, 0, 0, 0, 0, 3'd1, 8'h80, 0, 4'd5);
    tbl[29] = mk(0, 7'h73, 0, 0, 0, 0, 3'd1, 8'h80, 0, 4'd5);
    tbl[30] = mk(0, 7'h73, 0, 0, 1, 0, 3'd1, 8'hC0, 0, 4'd5);
    tbl[31] = mk(0, 7'h73, 0, 0, 1, 0, 3'd2, 8'h00, 0, 4'd5);
    tbl[32] = mk(1, 7'h73, 0, 0, 1, 0, 3'd7, 8'h00, 1, 4'd5);
    tbl[33] = mk(1, 7'h73, 1, 1, 1, 1, 3'd7, 8'h00, 1, 4'd5);
    tbl[34] = mk(0, 7'h73, 0, 0, 1, 1, 3'd7, 8'h00, 1, 4'd5);

    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset0");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      drive(tbl[i].start, tbl[i].op, tbl[i].br, tbl[i].z, tbl[i].ir, tbl[i].dr);
      #1;
      check($sformatf("v%0d_state", i),  32'(bus.state),       32'(tbl[i].st));
      check($sformatf("v%0d_en", i),     32'(en_mask()),       32'(tbl[i].en));
      check($sformatf("v%0d_halted", i), 32'(bus.halted),      32'(tbl[i].halted));
      check($sformatf("v%0d_err", i),    32'(bus.err),         32'(tbl[i].err));
      check($sformatf("v%0d_cnt", i),    32'(bus.instr_count), 32'(tbl[i].cnt));
    end

    // Reset out of HALT restores all reset values
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_reset_vals("halt_reset");

    // Fetch timeout: 15 wait cycles, err and HALT together
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("to_c1_state", 32'(bus.state), 32'd1);
    repeat (14) @(negedge clk);
    #1;
    check("to_c15_state", 32'(bus.state), 32'd1);
    check("to_c15_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    #1;
    check("to_state",  32'(bus.state),  32'd7);
    check("to_err",    32'(bus.err),    32'd1);
    check("to_halted", 32'(bus.halted), 32'd1);
    check("to_en",     32'(en_mask()),  32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    check("to_start_ignored", 32'(bus.state), 32'd7);
    check("to_err_sticky",    32'(bus.err),   32'd1);

    // Ready on exactly the 15th wait cycle wins over the fault
    bus.start = 1'b0;
    reset = 1'b1;
    #1;
    check("rdy15_reset_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.imem_ready = 1'b1;
    #1;
    check("rdy15_state", 32'(bus.state), 32'd1);
    check("rdy15_ir_we", 32'(bus.ir_we), 32'd1);
    @(negedge clk);
    #1;
    check("rdy15_next_state", 32'(bus.state), 32'd2);
    check("rdy15_err",        32'(bus.err),   32'd0);

    // Asynchronous reset during MEMORY
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 7'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("ar_mem_state",    32'(bus.state),    32'd4);
    check("ar_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_state",    32'(bus.state),       32'd0);
    check("ar_dmem_req", 32'(bus.dmem_req),    32'd0);
    check("ar_pc_we",    32'(bus.pc_we),       32'd0);
    check("ar_cnt",      32'(bus.instr_count), 32'd0);

    // 16 ALU instructions wrap a 4-bit retire counter
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 7'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (75) @(negedge clk);
    #1;
    check("wrap_cnt15",   32'(bus.instr_count), 32'd15);
    check("wrap_state15", 32'(bus.state),       32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("wrap_cnt0",   32'(bus.instr_count), 32'd0);
    check("wrap_state0", 32'(bus.state),       32'd1);
    check("wrap_err",    32'(bus.err),         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_control_fsm.md
# seq_control_fsm

Multi-cycle sequencer for the single-issue sequential RISC-V core. It steps each instruction through fetch, decode, execute, memory, writeback and PC-update phases. It issues the one-cycle enables that gate the instruction register, ALU, data memory, register file and PC register, and it drives the branch select into the PC adder. It also tracks retired instructions, halts on a system instruction, and flags memory timeouts.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- MEM_WAIT_MAX, 15, maximum cycles waited for imem_ready/dmem_ready before fault (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  7  instr[6:0] from instruction register, valid from DECODE onward
- branch  in  1  branch control from decoder
- ALU_zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word available
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load
- alu_en  out  1  ALU operand/result latch enable
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_we  out  1  register file write
- pc_we  out  1  PC register load
- pc_sel  out  1  1 = PC+imm (branch taken), 0 = PC+4
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired instructions
- halted  out  1  in HALT
- err  out  1  sticky memory-timeout fault

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PC_UPDATE=6, HALT=7.
- IDLE: all enables 0. If start=1, go to FETCH. start is ignored in all other states.
- FETCH: imem_req=1.
  - If imem_ready=1: ir_we=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - If opcode=7'h73: go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE: alu_en=1 for one cycle. Next state:
  - load (7'h03) or store (7'h23): MEMORY
  - branch (7'h63): PC_UPDATE
  - anything else: WRITEBACK
- MEMORY: dmem_req=1; dmem_we=1 iff opcode=7'h23. Wait for dmem_ready=1, then:
  - load: WRITEBACK
  - store: PC_UPDATE
- WRITEBACK: reg_we=1 for one cycle, then go to PC_UPDATE.
- PC_UPDATE: pc_we=1; pc_sel = branch & ALU_zero, combinational in this state. Increment instr_count, then go to FETCH.
- pc_sel is 0 in every state other than PC_UPDATE.
- HALT: halted=1 and all enables 0. The block remains in HALT until reset.
- Wait counter:
  - Width is $clog2(MEM_WAIT_MAX+1).
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle spent in FETCH or MEMORY with the relevant ready=0.
  - When it reaches MEM_WAIT_MAX with ready still 0: set err=1 and go to HALT.
  - If ready=1 in the same cycle the limit is hit, ready wins and no fault is raised.
- instr_count wraps from 2^CNT_W-1 to 0. It counts only completed PC_UPDATE cycles; the halting instruction is not counted.
- All enable outputs are decoded from the state register plus the listed inputs. No output is registered separately.

## Timing
- Reset values: state=IDLE, instr_count=0, err=0, halted=0, all enables 0, pc_sel=0.
- Reset asserted mid-instruction: the block returns to IDLE asynchronously and enables drop immediately. A half-finished instruction is not retired, and no PC write occurs.
- Latency with zero-wait memories, counted from the first FETCH cycle to the PC_UPDATE cycle inclusive:
  - ALU op: 5 cycles
  - load: 6 cycles
  - store: 5 cycles
  - branch: 4 cycles
- Each memory wait cycle adds 1.
- Exactly one pc_we pulse is issued per retired instruction. ir_we pulses exactly once per FETCH.
- instr_count updates on the clock edge that ends PC_UPDATE.
- Timeout: with ready held 0, err rises on the edge after MEM_WAIT_MAX wait cycles, at the same edge as the state changes to HALT.

## Test plan
- Reset, then start=1 with opcode=7'h33 and imem_ready=1 → states 1,2,3,5,6,1. reg_we and pc_we each pulse once, pc_sel=0, instr_count=1.
- Branch opcode=7'h63, branch=1, ALU_zero=1 → states 1,2,3,6 with pc_sel=1 during pc_we. Repeat with ALU_zero=0 → pc_sel=0.
- Load 7'h03 with dmem_ready held low for 3 cycles → MEMORY lasts 4 cycles with dmem_req=1 and dmem_we=0, then WRITEBACK. Store 7'h23 → dmem_we=1 and WRITEBACK is skipped.
- imem_ready held 0 with MEM_WAIT_MAX=15 → err=1, halted=1, state=7 after 15 wait cycles. Ready asserted on exactly the 15th cycle → no error.
- opcode=7'h73 → HALT after DECODE, instr_count unchanged. start then has no effect; reset returns to IDLE with all outputs at their reset values.
- Reset asserted during MEMORY → state=0 and dmem_req=0 immediately, without waiting for a clock edge. With CNT_W=4, 16 ALU instructions → instr_count wraps to 0.
